// File: rtl/burst_ram_arbiter_if.sv
// Bus bundle between two requesters (instruction fetch = 0, data = 1), the arbiter and the
// burst RAM controller. The slave modport is the arbiter's view; master is the environment's.
interface burst_ram_arbiter_if #(
  parameter int ADDRESS_BITWIDTH = 23,
  parameter int DATA_BITWIDTH    = 64
);
  localparam int MASK_BITWIDTH = DATA_BITWIDTH / 8;

  logic [1:0]                    req_cmd;
  logic [1:0]                    req_cmd_en;
  logic [2*ADDRESS_BITWIDTH-1:0] req_addr;
  logic [2*DATA_BITWIDTH-1:0]    req_wr_data;
  logic [2*MASK_BITWIDTH-1:0]    req_data_mask;
  logic [1:0]                    req_busy;
  logic [DATA_BITWIDTH-1:0]      req_rd_data;
  logic [1:0]                    req_rd_data_valid;

  logic                          br_cmd;
  logic                          br_cmd_en;
  logic [ADDRESS_BITWIDTH-1:0]   br_addr;
  logic [DATA_BITWIDTH-1:0]      br_wr_data;
  logic [MASK_BITWIDTH-1:0]      br_data_mask;
  logic [DATA_BITWIDTH-1:0]      br_rd_data;
  logic                          br_rd_data_valid;
  logic                          br_busy;
  logic                          br_init_calib;

  modport slave (
    input  req_cmd, req_cmd_en, req_addr, req_wr_data, req_data_mask,
    output req_busy, req_rd_data, req_rd_data_valid,
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy, br_init_calib
  );

  modport master (
    output req_cmd, req_cmd_en, req_addr, req_wr_data, req_data_mask,
    input  req_busy, req_rd_data, req_rd_data_valid,
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy, br_init_calib
  );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-port arbiter in front of a single burst RAM controller, one transaction in flight.
// Define BURST_RAM_ARBITER_FIXED_PRIORITY_EN to make port 0 always win ties instead of round robin.
module burst_ram_arbiter #(
  parameter int ADDRESS_BITWIDTH = 23,
  parameter int DATA_BITWIDTH    = 64
) (
  input logic                clk,
  input logic                rst,
  burst_ram_arbiter_if.slave bus
);
  localparam int MASK_BITWIDTH = DATA_BITWIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                      state, state_next;
  logic                        winner;
  logic                        accept;
  logic                        grant;
  logic                        seen_busy;
  logic                        cmd_q;
  logic [ADDRESS_BITWIDTH-1:0] addr_q;
  logic [DATA_BITWIDTH-1:0]    wr_data_q;
  logic [MASK_BITWIDTH-1:0]    mask_q;

`ifndef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
  logic last_grant;

  // Reset to port 1 so that port 0 takes the very first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= winner;
  end
`endif

  always_comb begin
    winner = bus.req_cmd_en[1];
    if (bus.req_cmd_en == 2'b11) begin
`ifdef BURST_RAM_ARBITER_FIXED_PRIORITY_EN
      winner = 1'b0;
`else
      winner = ~last_grant;
`endif
    end
  end

  assign accept = (state == IDLE) && bus.br_init_calib && !bus.br_busy && (|bus.req_cmd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        // Reads finish on the data beat; writes once the controller has gone busy and come back.
        if (!cmd_q) begin
          if (bus.br_rd_data_valid) state_next = IDLE;
        end else if (!bus.br_busy && seen_busy) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant     <= 1'b0;
      cmd_q     <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      mask_q    <= '0;
    end else if (accept) begin
      grant     <= winner;
      cmd_q     <= bus.req_cmd[winner];
      addr_q    <= winner ? bus.req_addr[2*ADDRESS_BITWIDTH-1:ADDRESS_BITWIDTH]
                          : bus.req_addr[ADDRESS_BITWIDTH-1:0];
      wr_data_q <= winner ? bus.req_wr_data[2*DATA_BITWIDTH-1:DATA_BITWIDTH]
                          : bus.req_wr_data[DATA_BITWIDTH-1:0];
      mask_q    <= winner ? bus.req_data_mask[2*MASK_BITWIDTH-1:MASK_BITWIDTH]
                          : bus.req_data_mask[MASK_BITWIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                seen_busy <= 1'b0;
    else if (state == ISSUE)                seen_busy <= 1'b0;
    else if (state == WAIT && bus.br_busy)  seen_busy <= 1'b1;
  end

  assign bus.br_cmd_en    = (state == ISSUE);
  assign bus.br_cmd       = cmd_q;
  assign bus.br_addr      = addr_q;
  assign bus.br_wr_data   = wr_data_q;
  assign bus.br_data_mask = mask_q;
  assign bus.req_rd_data  = bus.br_rd_data;

  always_comb begin
    bus.req_rd_data_valid = 2'b00;
    if (state == WAIT && !cmd_q && bus.br_rd_data_valid)
      bus.req_rd_data_valid[grant] = 1'b1;
  end

  // A requesting port that is not being accepted this cycle counts as blocked.
  always_comb begin
    bus.req_busy = 2'b11;
    if (bus.br_init_calib && state == IDLE) begin
      bus.req_busy = bus.req_cmd_en;
      if (accept) bus.req_busy[winner] = 1'b0;
    end
  end
endmodule
